// File: rtl/qspi_responder.sv
// QSPI responder: decodes controller command/address/data nibbles and services them from a byte-wide sync memory.
// Optional QSPI_RESP_SPI_CMD_EN: single-bit command phase after reset, switched to quad by command 0x35.
module qspi_responder #(
    parameter int PA         = 24,
    parameter int READ_DUMMY = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs_n,
    input  logic [3:0]    io_in,
    output logic [3:0]    io_out,
    output logic [3:0]    io_oe,
    output logic [PA-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [7:0]    mem_rdata,
    output logic          quad_mode
);

    typedef enum logic [2:0] {IDLE, CMD_S, CMD_Q, ADDR, WDATA, DUMMY, RDATA, SKIP} state_t;

    state_t        state;
    logic [23:0]   sh;
    logic [3:0]    cnt;
    logic          is_rd;
    logic          lo_next;
    logic [7:0]    byte_q;
    logic [PA-1:0] addr;
    logic [7:0]    cmd_byte;
    logic          cmd_done;
    logic [23:0]   addr_full;

`ifdef QSPI_RESP_SPI_CMD_EN
    logic quad_q;
    assign quad_mode = quad_q;
    always_comb begin
        cmd_byte = (state == CMD_Q) ? {sh[3:0], io_in} : {sh[6:0], io_in[0]};
        cmd_done = (state == CMD_Q) || (cnt == 4'd6);
    end
`else
    assign quad_mode = 1'b1;
    always_comb begin
        cmd_byte = {sh[3:0], io_in};
        cmd_done = 1'b1;
    end
`endif

    assign addr_full = {sh[19:0], io_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            is_rd     <= 1'b0;
            lo_next   <= 1'b0;
            byte_q    <= '0;
            addr      <= '0;
            io_out    <= '0;
            io_oe     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
`ifdef QSPI_RESP_SPI_CMD_EN
            quad_q    <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (cs_n) begin
                // deselect abandons any partial byte or in-flight read
                state <= IDLE;
                io_oe <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sh    <= quad_mode ? {20'd0, io_in} : {23'd0, io_in[0]};
                        cnt   <= '0;
                        state <= quad_mode ? CMD_Q : CMD_S;
                    end
`ifdef QSPI_RESP_SPI_CMD_EN
                    CMD_S, CMD_Q: begin
`else
                    CMD_Q: begin
`endif
                        if (cmd_done) begin
                            cnt <= '0;
                            case (cmd_byte)
                                8'hEB: begin is_rd <= 1'b1; state <= ADDR; end
                                8'h38: begin is_rd <= 1'b0; state <= ADDR; end
`ifdef QSPI_RESP_SPI_CMD_EN
                                8'h35: begin quad_q <= 1'b1; state <= SKIP; end
`endif
                                default: state <= SKIP;
                            endcase
                        end else begin
                            sh  <= {sh[22:0], io_in[0]};
                            cnt <= cnt + 4'd1;
                        end
                    end
                    ADDR: begin
                        sh  <= addr_full;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd5) begin
                            addr    <= addr_full[PA-1:0];
                            lo_next <= 1'b0;
                            cnt     <= 4'(READ_DUMMY - 2);
                            if (is_rd) begin
                                mem_re   <= 1'b1;
                                mem_addr <= addr_full[PA-1:0];
                                state    <= DUMMY;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (!lo_next) begin
                            byte_q[7:4] <= io_in;
                            lo_next     <= 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= {byte_q[7:4], io_in};
                            addr      <= addr + 1'b1;
                            lo_next   <= 1'b0;
                        end
                    end
                    // the last dummy clock and every high-nibble clock share the same load
                    DUMMY, RDATA: begin
                        if (state == DUMMY && cnt != 4'd0) begin
                            cnt <= cnt - 4'd1;
                        end else if (state == RDATA && lo_next) begin
                            io_out  <= byte_q[3:0];
                            lo_next <= 1'b0;
                        end else begin
                            io_out   <= mem_rdata[7:4];
                            io_oe    <= 4'hF;
                            byte_q   <= mem_rdata;
                            mem_re   <= 1'b1;
                            mem_addr <= addr + 1'b1;
                            addr     <= addr + 1'b1;
                            lo_next  <= 1'b1;
                            state    <= RDATA;
                        end
                    end
                    SKIP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
